alu_pipe_core: RTL and testbench

- Parametrised, pipelined successor to the 8-bit opcode-driven ALU top level.
- Takes an opcode plus two operands through a valid/ready handshake, decodes in stage 1, executes in stage 2, and returns a registered result with a full flag set.
- Adds an iterative multi-cycle multiply, backpressure, and carry/negative/overflow flags.
- Sits between the instruction issue logic and the register-file write-back.

---
 rtl/alu_pipe_core.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_alu_pipe_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_core.sv
// Two-stage pipelined ALU: decode register, then an execute stage with an
// iterative shift-add multiplier. Valid/ready handshakes on both sides.
module alu_pipe_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             busy
);

   localparam int SH_BITS = $clog2(WIDTH);
   localparam int CNT_W   = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOT  = 4'd5,
      OP_SHL  = 4'd6,
      OP_SHR  = 4'd7,
      OP_SRA  = 4'd8,
      OP_ROL  = 4'd9,
      OP_ROR  = 4'd10,
      OP_CMP  = 4'd11,
      OP_INC  = 4'd12,
      OP_DEC  = 4'd13,
      OP_PASS = 4'd14,
      OP_MUL  = 4'd15
   } op_e;

   typedef enum logic {
      S_IDLE,
      S_MUL_BUSY
   } state_e;

   // Stage 1 registers
   logic             dec_valid_q, dec_valid_d;
   op_e              dec_op_q, dec_op_d;
   logic [WIDTH-1:0] dec_a_q, dec_a_d;
   logic [WIDTH-1:0] dec_b_q, dec_b_d;
   logic             dec_consumed;

   // Stage 2 registers
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;

   logic               out_free;
   logic               accept;

   // Combinational datapath
   logic [SH_BITS-1:0] sh;
   logic [WIDTH-1:0]   opnd_b;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     dif_ext;
   logic               add_v;
   logic               sub_v;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [WIDTH:0]     sra_ext;
   logic [WIDTH-1:0]   rol_res;
   logic [WIDTH-1:0]   ror_res;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   alu_basis;
   logic               alu_c;
   logic               alu_v;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] final_prod;

   assign out_free = !out_valid_q || out_ready;
   assign in_ready = !dec_valid_q || dec_consumed;
   assign accept   = in_valid && in_ready;

   assign sh      = dec_b_q[SH_BITS-1:0];
   assign opnd_b  = (dec_op_q == OP_INC || dec_op_q == OP_DEC) ? ONE_W : dec_b_q;
   assign sum_ext = {1'b0, dec_a_q} + {1'b0, opnd_b};
   // Bit WIDTH of the zero-extended difference is the unsigned borrow.
   assign dif_ext = {1'b0, dec_a_q} - {1'b0, opnd_b};
   assign add_v   = (dec_a_q[WIDTH-1] == opnd_b[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != dec_a_q[WIDTH-1]);
   assign sub_v   = (dec_a_q[WIDTH-1] != opnd_b[WIDTH-1]) &&
                    (dif_ext[WIDTH-1] != dec_a_q[WIDTH-1]);
   // One guard bit on the exit side captures the last bit shifted out,
   // and is naturally 0 for a zero shift amount.
   assign shl_ext = {1'b0, dec_a_q} << sh;
   assign shr_ext = {dec_a_q, 1'b0} >> sh;
   assign sra_ext = $signed({dec_a_q, 1'b0}) >>> sh;
   assign rol_res = (dec_a_q << sh) | (dec_a_q >> (WIDTH - int'(sh)));
   assign ror_res = (dec_a_q >> sh) | (dec_a_q << (WIDTH - int'(sh)));

   assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign final_prod = (cnt_q == CNT_FULL) ? acc_q : acc_step;

   // Single-cycle ALU result and flags for the op held in stage 1
   always_comb begin
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      case (dec_op_q)
         OP_ADD, OP_INC: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = add_v;
         end
         OP_SUB, OP_DEC: begin
            alu_res = dif_ext[WIDTH-1:0];
            alu_c   = dif_ext[WIDTH];
            alu_v   = sub_v;
         end
         OP_CMP: begin
            alu_res = dec_a_q;
            alu_c   = dif_ext[WIDTH];
            alu_v   = sub_v;
         end
         OP_AND:  alu_res = dec_a_q & dec_b_q;
         OP_OR:   alu_res = dec_a_q | dec_b_q;
         OP_XOR:  alu_res = dec_a_q ^ dec_b_q;
         OP_NOT:  alu_res = ~dec_a_q;
         OP_SHL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         OP_SRA: begin
            alu_res = sra_ext[WIDTH:1];
            alu_c   = sra_ext[0];
         end
         OP_ROL:  alu_res = rol_res;
         OP_ROR:  alu_res = ror_res;
         OP_PASS: alu_res = dec_b_q;
         default: alu_res = '0;
      endcase
      alu_basis = (dec_op_q == OP_CMP) ? dif_ext[WIDTH-1:0] : alu_res;
   end

   // Stage 1 next state: consume to execute, then optionally refill
   always_comb begin
      dec_valid_d = dec_valid_q;
      dec_op_d    = dec_op_q;
      dec_a_d     = dec_a_q;
      dec_b_d     = dec_b_q;
      if (dec_consumed) begin
         dec_valid_d = 1'b0;
      end
      if (accept) begin
         dec_valid_d = 1'b1;
         dec_op_d    = op_e'(op_code);
         dec_a_d     = a;
         dec_b_d     = b;
      end
   end

   // Stage 1 decode register
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_valid_q <= 1'b0;
         dec_op_q    <= OP_ADD;
         dec_a_q     <= '0;
         dec_b_q     <= '0;
      end else begin
         dec_valid_q <= dec_valid_d;
         dec_op_q    <= dec_op_d;
         dec_a_q     <= dec_a_d;
         dec_b_q     <= dec_b_d;
      end
   end

   // Execute FSM next state, multiplier iteration and result-register load
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      out_valid_d  = out_valid_q && !out_ready;
      res_d        = res_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      neg_d        = neg_q;
      ovf_d        = ovf_q;
      dec_consumed = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dec_valid_q) begin
               if (dec_op_q == OP_MUL) begin
                  acc_d        = '0;
                  mcand_d      = {{WIDTH{1'b0}}, dec_a_q};
                  mplier_d     = dec_b_q;
                  cnt_d        = '0;
                  state_d      = S_MUL_BUSY;
                  dec_consumed = 1'b1;
               end else if (out_free) begin
                  res_d        = alu_res;
                  zero_d       = (alu_basis == '0);
                  carry_d      = alu_c;
                  neg_d        = alu_basis[WIDTH-1];
                  ovf_d        = alu_v;
                  out_valid_d  = 1'b1;
                  dec_consumed = 1'b1;
               end
            end
         end
         S_MUL_BUSY: begin
            if (cnt_q != CNT_FULL) begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_ONE;
            end
            // The final iteration and the result load share one edge when
            // the output is free; otherwise the counter parks at WIDTH and
            // the finished product waits in the accumulator.
            if ((cnt_q >= CNT_LAST) && out_free) begin
               res_d       = final_prod[WIDTH-1:0];
               zero_d      = (final_prod[WIDTH-1:0] == '0);
               carry_d     = |final_prod[2*WIDTH-1:WIDTH];
               neg_d       = final_prod[WIDTH-1];
               ovf_d       = 1'b0;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Execute-stage state, multiplier and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_out   = res_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q == S_MUL_BUSY);

endmodule

// File: tb/tb_alu_pipe_core.sv
// Bench for alu_pipe_core: directed cases plus randomized traffic checked
// against an arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe_core;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z;
      logic         c;
      logic         n;
      logic         v;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op_code;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] alu_out;
   logic         zero;
   logic         carry;
   logic         negative;
   logic         overflow;
   logic         busy;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   logic accepted;
   logic hold_prev;
   res_t held;
   int   rdy_mode;
   int   stall_left;

   alu_pipe_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_code   (op_code),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .zero      (zero),
      .carry     (carry),
      .negative  (negative),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   // Reference model: plain integer arithmetic on the operation rules.
   function automatic res_t model(input int op, input int ua, input int ub);
      longint mask = (64'sd1 <<< W) - 1;
      longint half = 64'sd1 <<< (W - 1);
      longint sa   = (ua >= half) ? ua - 2 * half : ua;
      longint sb   = (ub >= half) ? ub - 2 * half : ub;
      longint r = 0, basis = 0, s, d, sv, bb, sbb, p;
      int     n = ub % W;
      logic   c = 1'b0, v = 1'b0;
      res_t   m;
      case (op)
         0, 12: begin
            bb = (op == 12) ? 1 : ub;
            sbb = (op == 12) ? 1 : sb;
            s = ua + bb; r = s & mask; c = (s > mask);
            sv = sa + sbb; v = (sv > half - 1) || (sv < -half); basis = r;
         end
         1, 11, 13: begin
            bb = (op == 13) ? 1 : ub;
            sbb = (op == 13) ? 1 : sb;
            d = (ua - bb) & mask; c = (ua < bb);
            sv = sa - sbb; v = (sv > half - 1) || (sv < -half);
            r = (op == 11) ? ua : d; basis = d;
         end
         2: r = ua & ub;
         3: r = ua | ub;
         4: r = ua ^ ub;
         5: r = ~longint'(ua) & mask;
         6: begin r = (ua << n) & mask; c = (n != 0) && (((ua >> (W - n)) & 1) != 0); end
         7: begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
         8: begin r = (sa >>> n) & mask; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
         9: r = ((ua << n) | (ua >> (W - n))) & mask;
         10: r = ((ua >> n) | (ua << (W - n))) & mask;
         14: r = ub;
         default: begin p = longint'(ua) * ub; r = p & mask; c = ((p >> W) != 0); end
      endcase
      if (!(op inside {0, 1, 11, 12, 13})) basis = r;
      m.r = r[W-1:0];
      m.z = (basis == 0);
      m.c = c;
      m.n = basis[W-1];
      m.v = v;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive out_ready, sample the handshakes just before the edge,
   // update the expectation queue, then move to the next falling edge.
   task automatic cycle();
      res_t e;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = 1'b1;
      #1;
      accepted = 1'b0;
      if (hold_prev) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_data", {alu_out, zero, carry, negative, overflow}, held);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
         else begin
            e = exp_q.pop_front();
            chk("result", {alu_out, zero, carry, negative, overflow}, e);
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(int'(op_code), int'(a), int'(b)));
         accepted = 1'b1;
      end
      hold_prev = out_valid && !out_ready;
      held = {alu_out, zero, carry, negative, overflow};
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      op_code = op; a = x; b = y; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (accepted) break;
      end
      chk("accept_timeout", accepted, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic await_out();
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         cycle();
      end
      chk("await_out_valid", out_valid, 1'b1);
   endtask

   task automatic out_is(input string tag, input logic [W-1:0] r, input logic z,
                         input logic c, input logic n, input logic v);
      chk(tag, {alu_out, zero, carry, negative, overflow}, {r, z, c, n, v});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op_code = '0; a = '0; b = '0; out_ready = 1'b1;
      rdy_mode = 0; stall_left = 0; hold_prev = 1'b0; held = '0; accepted = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_flags", {alu_out, zero, carry, negative, overflow}, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // ADD with exact latency
      issue(4'd0, 8'hFF, 8'h01);
      chk("add_lat_early", out_valid, 1'b0);
      cycle();
      chk("add_lat_valid", out_valid, 1'b1);
      out_is("add_ff_01", 8'h00, 1, 1, 0, 0);
      cycle();

      issue(4'd1, 8'h80, 8'h01);  await_out(); out_is("sub_80_01", 8'h7F, 0, 0, 0, 1); cycle();
      issue(4'd11, 8'h05, 8'h05); await_out(); out_is("cmp_5_5",   8'h05, 1, 0, 0, 0); cycle();
      issue(4'd13, 8'h00, 8'h00); await_out(); out_is("dec_00",    8'hFF, 0, 1, 1, 0); cycle();
      issue(4'd6, 8'h81, 8'h01);  await_out(); out_is("shl_81_1",  8'h02, 0, 1, 0, 0); cycle();
      issue(4'd8, 8'h80, 8'h03);  await_out(); out_is("sra_80_3",  8'hF0, 0, 0, 1, 0); cycle();
      issue(4'd10, 8'h01, 8'h09); await_out(); out_is("ror_01_9",  8'h80, 0, 0, 1, 0); cycle();
      issue(4'd7, 8'h55, 8'h00);  await_out(); out_is("shr_55_0",  8'h55, 0, 0, 0, 0); cycle();

      // MUL followed by ADD waiting in stage 1
      issue(4'd15, 8'h10, 8'h20);
      op_code = 4'd0; a = 8'd3; b = 8'd4; in_valid = 1'b1;
      cycle();
      chk("mul_add_accept", accepted, 1'b1);
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("mul_busy", busy, 1'b1);
         chk("mul_no_out", out_valid, 1'b0);
         chk("mul_in_ready_low", in_ready, 1'b0);
         cycle();
      end
      chk("mul_busy_done", busy, 1'b0);
      chk("mul_out_valid", out_valid, 1'b1);
      out_is("mul_10_20", 8'h00, 1, 1, 0, 0);
      cycle();
      chk("add_after_mul_valid", out_valid, 1'b1);
      out_is("add_3_4", 8'h07, 0, 0, 0, 0);
      cycle();

      // Backpressure stream: ADD k+1 with five stalled cycles
      stall_left = 5;
      issue(4'd0, 8'd0, 8'd1);
      issue(4'd0, 8'd1, 8'd1);
      op_code = 4'd0; a = 8'd2; b = 8'd1; in_valid = 1'b1;
      #1;
      chk("stream_in_ready_low", in_ready, 1'b0);
      chk("stream_head", alu_out, 8'd1);
      issue(4'd0, 8'd2, 8'd1);
      for (int k = 3; k < 6; k++) issue(4'd0, W'(k), 8'd1);
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle();
      chk("stream_drained", exp_q.size(), 0);

      // Reset during a multiply aborts it
      issue(4'd15, 8'hC3, 8'h5A);
      cycle(); cycle(); cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      hold_prev = 1'b0;
      #1;
      chk("rstmul_out_valid", out_valid, 1'b0);
      chk("rstmul_busy", busy, 1'b0);
      chk("rstmul_in_ready", in_ready, 1'b1);
      issue(4'd0, 8'd1, 8'd1);
      chk("rstmul_add_early", out_valid, 1'b0);
      cycle();
      out_is("rstmul_add", 8'h02, 0, 0, 0, 0);
      cycle();

      // Randomized traffic with random backpressure
      rdy_mode = 1;
      for (int t = 0; t < 400; t++) begin
         repeat ($urandom_range(0, 1)) cycle();
         issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      end
      rdy_mode = 0;
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycle();
      chk("final_drained", exp_q.size(), 0);
      cycle();
      chk("final_out_valid", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
